// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory read arbiter.
package mem_arb_pkg;

    // Arbiter control state: INIT while the memory loads, RUN afterwards.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    // Requester indices; also the encoding of the response tag and grant pointer.
    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DLOAD  = 1'b1;

    // Arbitration policy selectors for the ARB_MODE parameter.
    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

endpackage

// File: rtl/mem_arbiter_arb2_grant.sv
// Combinational two-way grant: picks at most one of two valid requesters.
module arb2_grant
    import mem_arb_pkg::*;
#(
    parameter int unsigned ARB_MODE = ARB_RR
) (
    input  logic       i_valid_0,
    input  logic       i_valid_1,
    input  logic       i_last_ptr,
    input  logic       i_starve,
    output logic [1:0] o_grant_c
);

    logic w_tie_to_1;

    // On a tie, round-robin favours the port not granted last; fixed
    // priority favours port 0 unless port 1 has been starved too long.
    assign w_tie_to_1 = (ARB_MODE == ARB_FIXED) ? i_starve
                                                : (i_last_ptr == PORT_IFETCH);

    // One-hot grant, bit 0 = fetch port, bit 1 = load port.
    always_comb begin
        o_grant_c = 2'b00;
        if (i_valid_0 && i_valid_1) begin
            o_grant_c = w_tie_to_1 ? 2'b10 : 2'b01;
        end else if (i_valid_0) begin
            o_grant_c = 2'b01;
        end else if (i_valid_1) begin
            o_grant_c = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory's single synchronous read port between instruction
// fetch (port 0) and data load (port 1), and steers the one-cycle-latency
// read data back to whichever port issued the access.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDRESSLEN = 32,
    parameter int unsigned ARB_MODE   = 0,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_0,
    input  logic                  req_valid_1,
    input  logic [ADDRESSLEN-1:0] req_addr_0,
    input  logic [ADDRESSLEN-1:0] req_addr_1,
    output logic                  req_ready_0,
    output logic                  req_ready_1,
    output logic                  rsp_valid_0,
    output logic                  rsp_valid_1,
    output logic [XLEN-1:0]       rsp_data_0,
    output logic [XLEN-1:0]       rsp_data_1,
    output logic [ADDRESSLEN-1:0] mem_addr,
    input  logic [XLEN-1:0]       mem_rdata
);

    // Counter must hold 0..MAX_WAIT; keep at least one bit when MAX_WAIT is 0.
    localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    arb_state_e            r_state;
    logic                  r_last_ptr;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic                  r_pend;
    logic                  r_tag;
    logic [ADDRESSLEN-1:0] r_addr_hold;

    logic                  w_run;
    logic                  w_valid_0;
    logic                  w_valid_1;
    logic                  w_starve;
    logic [1:0]            w_grant;
    logic                  w_accept;
    logic                  w_acc_port;

    // Only arbitrate in RUN and never while reset is being applied.
    assign w_run     = (r_state == RUN) && !reset;
    assign w_valid_0 = req_valid_0 && w_run;
    assign w_valid_1 = req_valid_1 && w_run;
    assign w_starve  = (r_wait_cnt == WAIT_W'(MAX_WAIT));

    arb2_grant #(
        .ARB_MODE (ARB_MODE)
    ) u_grant (
        .i_valid_0 (w_valid_0),
        .i_valid_1 (w_valid_1),
        .i_last_ptr(r_last_ptr),
        .i_starve  (w_starve),
        .o_grant_c (w_grant)
    );

    // Grants are only ever issued to valid ports, so a grant is an acceptance.
    assign req_ready_0 = w_grant[0];
    assign req_ready_1 = w_grant[1];
    assign w_accept    = |w_grant;
    assign w_acc_port  = w_grant[1];

    // Present the winner's address this cycle; otherwise keep the last one.
    always_comb begin
        mem_addr = r_addr_hold;
        if (w_grant[1]) begin
            mem_addr = req_addr_1;
        end else if (w_grant[0]) begin
            mem_addr = req_addr_0;
        end
    end

    // Control FSM: one INIT cycle after reset for memory load, then RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= INIT;
        end else begin
            case (r_state)
                INIT:    r_state <= RUN;
                RUN:     r_state <= RUN;
                default: r_state <= INIT;
            endcase
        end
    end

    // Last-grant pointer and held address move only on an acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_ptr  <= PORT_DLOAD;
            r_addr_hold <= '0;
        end else if (w_accept) begin
            r_last_ptr  <= w_acc_port;
            r_addr_hold <= mem_addr;
        end
    end

    // Starvation counter: consecutive RUN cycles port 1 waited, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if ((ARB_MODE == ARB_FIXED) && w_run) begin
            if (!req_valid_1 || w_grant[1]) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt < WAIT_W'(MAX_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
        end
    end

    // Remember who was accepted so next cycle's read data goes back to them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= 1'b0;
            r_tag  <= PORT_IFETCH;
        end else begin
            r_pend <= w_accept;
            if (w_accept) begin
                r_tag <= w_acc_port;
            end
        end
    end

    assign rsp_valid_0 = r_pend && (r_tag == PORT_IFETCH);
    assign rsp_valid_1 = r_pend && (r_tag == PORT_DLOAD);
    assign rsp_data_0  = rsp_valid_0 ? mem_rdata : '0;
    assign rsp_data_1  = rsp_valid_1 ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances (round-robin, fixed
// priority with MAX_WAIT=4, fixed priority with MAX_WAIT=0) share one
// stimulus stream; each has its own memory and reference model.
module tb_mem_arbiter;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        v0, v1;
    logic [31:0] a0, a1;

    logic        rdy0 [3];
    logic        rdy1 [3];
    logic        rv0  [3];
    logic        rv1  [3];
    logic [31:0] rd0  [3];
    logic [31:0] rd1  [3];
    logic [31:0] maddr [3];
    logic [31:0] mrdata [3];

    logic [31:0] mem [64];

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    // reference model state
    int          m_mode  [3];
    int          m_maxw  [3];
    int          m_last  [3];
    int          m_refused [3];
    logic [31:0] m_addr  [3];
    int          m_live;

    exp_t q_0[$];
    exp_t q_1[$];
    exp_t q_2[$];

    mem_arbiter #(.XLEN(32), .ADDRESSLEN(32), .ARB_MODE(0), .MAX_WAIT(4)) u_rr (
        .clk(clk), .reset(reset),
        .req_valid_0(v0), .req_valid_1(v1), .req_addr_0(a0), .req_addr_1(a1),
        .req_ready_0(rdy0[0]), .req_ready_1(rdy1[0]),
        .rsp_valid_0(rv0[0]), .rsp_valid_1(rv1[0]),
        .rsp_data_0(rd0[0]), .rsp_data_1(rd1[0]),
        .mem_addr(maddr[0]), .mem_rdata(mrdata[0])
    );

    mem_arbiter #(.XLEN(32), .ADDRESSLEN(32), .ARB_MODE(1), .MAX_WAIT(4)) u_fx4 (
        .clk(clk), .reset(reset),
        .req_valid_0(v0), .req_valid_1(v1), .req_addr_0(a0), .req_addr_1(a1),
        .req_ready_0(rdy0[1]), .req_ready_1(rdy1[1]),
        .rsp_valid_0(rv0[1]), .rsp_valid_1(rv1[1]),
        .rsp_data_0(rd0[1]), .rsp_data_1(rd1[1]),
        .mem_addr(maddr[1]), .mem_rdata(mrdata[1])
    );

    mem_arbiter #(.XLEN(32), .ADDRESSLEN(32), .ARB_MODE(1), .MAX_WAIT(0)) u_fx0 (
        .clk(clk), .reset(reset),
        .req_valid_0(v0), .req_valid_1(v1), .req_addr_0(a0), .req_addr_1(a1),
        .req_ready_0(rdy0[2]), .req_ready_1(rdy1[2]),
        .rsp_valid_0(rv0[2]), .rsp_valid_1(rv1[2]),
        .rsp_data_0(rd0[2]), .rsp_data_1(rd1[2]),
        .mem_addr(maddr[2]), .mem_rdata(mrdata[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous word memories, one per instance, 1-cycle read latency
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) mrdata[k] <= mem[maddr[k][7:2]];
    end

    function automatic void sb_push(input int k, input exp_t e);
        case (k)
            0: q_0.push_back(e);
            1: q_1.push_back(e);
            default: q_2.push_back(e);
        endcase
    endfunction

    function automatic bit sb_pop_due(input int k, output exp_t e);
        bit got = 0;
        e = '{port: -1, data: 32'h0, due: 0};
        case (k)
            0: if (q_0.size() > 0 && q_0[0].due <= cyc) begin e = q_0.pop_front(); got = 1; end
            1: if (q_1.size() > 0 && q_1[0].due <= cyc) begin e = q_1.pop_front(); got = 1; end
            default: if (q_2.size() > 0 && q_2[0].due <= cyc) begin e = q_2.pop_front(); got = 1; end
        endcase
        return got;
    endfunction

    function automatic int sb_size(input int k);
        case (k)
            0: return q_0.size();
            1: return q_1.size();
            default: return q_2.size();
        endcase
    endfunction

    // Monitor: compare every presented response against the scoreboard.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            exp_t        e;
            bit          have;
            bit          got_v;
            int          got_port;
            logic [31:0] got_data;
            have  = sb_pop_due(k, e);
            got_v = (rv0[k] === 1'b1) || (rv1[k] === 1'b1);
            got_port = (rv1[k] === 1'b1) ? 1 : 0;
            got_data = (got_port == 1) ? rd1[k] : rd0[k];
            if (have || got_v) begin
                n_chk++;
                if (!have) begin
                    n_err++;
                    $display("FAIL rsp_unexpected inst%0d cyc%0d: got port%0d data %h, required none",
                             k, cyc, got_port, got_data);
                end else if (!got_v) begin
                    n_err++;
                    $display("FAIL rsp_missing inst%0d cyc%0d: got none, required port%0d data %h",
                             k, cyc, e.port, e.data);
                end else if ((rv0[k] === 1'b1 && rv1[k] === 1'b1) ||
                             got_port != e.port || got_data !== e.data) begin
                    n_err++;
                    $display("FAIL rsp_data inst%0d cyc%0d: got v=%b%b data %h, required port%0d data %h",
                             k, cyc, rv1[k], rv0[k], got_data, e.port, e.data);
                end
            end
            n_chk++;
            if ((rv0[k] !== 1'b1 && rd0[k] !== 32'h0) || (rv1[k] !== 1'b1 && rd1[k] !== 32'h0)) begin
                n_err++;
                $display("FAIL rsp_idle_zero inst%0d cyc%0d: got d0=%h d1=%h with v=%b%b, required 0 on idle port",
                         k, cyc, rd0[k], rd1[k], rv1[k], rv0[k]);
            end
        end
    end

    // Drive one cycle of stimulus, predict grants and queue expected responses.
    task automatic step(input bit rst, input bit iv0, input bit iv1,
                        input logic [31:0] ia0, input logic [31:0] ia1);
        int          g;
        bit          run;
        logic [31:0] exp_addr;
        exp_t        e;
        @(posedge clk);
        #1;
        reset = rst; v0 = iv0; v1 = iv1; a0 = ia0; a1 = ia1;
        @(negedge clk);
        run = !rst && (m_live >= 1);
        for (int k = 0; k < 3; k++) begin
            g = -1;
            if (run) begin
                if (iv0 && iv1) begin
                    if (m_mode[k] == 0) g = (m_last[k] == 0) ? 1 : 0;
                    else                g = (m_refused[k] >= m_maxw[k]) ? 1 : 0;
                end else if (iv0) g = 0;
                else if (iv1)     g = 1;
            end
            n_chk++;
            if (rdy0[k] !== (g == 0) || rdy1[k] !== (g == 1)) begin
                n_err++;
                $display("FAIL ready inst%0d cyc%0d: got r1r0=%b%b, required %b%b",
                         k, cyc, rdy1[k], rdy0[k], (g == 1), (g == 0));
            end
            exp_addr = (g == 0) ? ia0 : (g == 1) ? ia1 : m_addr[k];
            if (!rst) begin
                n_chk++;
                if (maddr[k] !== exp_addr) begin
                    n_err++;
                    $display("FAIL mem_addr inst%0d cyc%0d: got %h, required %h", k, cyc, maddr[k], exp_addr);
                end
            end
            if (g >= 0) begin
                e.port = g;
                e.data = 32'h1000_0000 + 32'((exp_addr >> 2) % 64);
                e.due  = cyc + 1;
                sb_push(k, e);
            end
            if (rst) begin
                m_last[k] = 1; m_refused[k] = 0; m_addr[k] = 32'h0;
            end else if (run) begin
                if (g >= 0) begin
                    m_last[k] = g;
                    m_addr[k] = exp_addr;
                end
                if (iv1 && g != 1)
                    m_refused[k] = (m_refused[k] < m_maxw[k]) ? m_refused[k] + 1 : m_maxw[k];
                else
                    m_refused[k] = 0;
            end
        end
        m_live = rst ? 0 : m_live + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        m_mode = '{0, 1, 1};
        m_maxw = '{4, 4, 0};
        for (int k = 0; k < 3; k++) begin
            m_last[k] = 1; m_refused[k] = 0; m_addr[k] = 32'h0;
        end
        m_live = 0;
        reset = 1'b1; v0 = 1'b1; v1 = 1'b1; a0 = 32'h08; a1 = 32'h0C;

        // reset, INIT, then both ports contending
        step(1, 1, 1, 32'h08, 32'h0C);
        for (int i = 0; i < 9; i++) step(0, 1, 1, 32'h08, 32'h0C);

        // port 1 streaming alone
        step(0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 1, 32'h0, 32'h00);
        step(0, 0, 1, 32'h0, 32'h04);
        step(0, 0, 1, 32'h0, 32'h08);
        step(0, 0, 0, 32'h0, 32'h0);

        // misaligned address passed through unchanged
        step(0, 1, 0, 32'h17, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0);

        // long contention: starvation guard pattern on fixed-priority instances
        for (int i = 0; i < 14; i++) step(0, 1, 1, 32'h10 + 32'(i * 4), 32'h80 + 32'(i * 4));

        // acceptance followed immediately by reset, then recovery
        step(0, 1, 0, 32'h20, 32'h0);
        step(1, 1, 1, 32'h24, 32'h28);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 32'h30, 32'h34);

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0,
                 32'($urandom_range(0, 255)),
                 32'($urandom_range(0, 255)));
        end

        // drain and confirm nothing was left unanswered
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (sb_size(k) != 0) begin
                n_err++;
                $display("FAIL drain inst%0d: got %0d outstanding, required 0", k, sb_size(k));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
